rs_issue_scheduler: RTL and testbench

//  Control plane for the reservation station: owns per-entry busy, operand-pending and ROB-tag state.

---
 rtl/rs_issue_scheduler_pkg.sv | 22 ++
 rtl/rs_issue_scheduler_lowest_free.sv | 21 ++
 rtl/rs_issue_scheduler.sv | 177 +++++++++++++++++
 tb/tb_rs_issue_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_issue_scheduler_pkg.sv
// Shared sizing and helper types for the reservation-station issue scheduler.
package rs_issue_scheduler_pkg;

    localparam int RS_SIZE = 16;
    localparam int IDX_W   = 4;
    localparam int TAG_W   = 4;

    typedef logic [RS_SIZE-1:0] rs_vec_t;
    typedef logic [IDX_W-1:0]   rs_idx_t;
    typedef logic [TAG_W-1:0]   rob_tag_t;
    typedef logic [IDX_W:0]     rs_cnt_t;

    localparam rs_cnt_t RS_FULL_COUNT = rs_cnt_t'(RS_SIZE);

    function automatic rs_vec_t idx_onehot(input rs_idx_t idx);
        rs_vec_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rs_issue_scheduler_lowest_free.sv
// Priority encoder: index of the lowest set request bit plus a found flag.
module rs_issue_scheduler_lowest_free
    import rs_issue_scheduler_pkg::*;
(
    input  logic [RS_SIZE-1:0] req_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Reservation-station control plane: entry allocation, CDB operand wakeup and
// oldest-ready issue selection driven by a pairwise age matrix.
module rs_issue_scheduler
    import rs_issue_scheduler_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               rob_clear_up,
    input  logic               alloc_valid,
    output logic               alloc_rdy,
    output logic [IDX_W-1:0]   alloc_idx,
    input  logic               alloc_q1_pend,
    input  logic [TAG_W-1:0]   alloc_q1_tag,
    input  logic               alloc_q2_pend,
    input  logic [TAG_W-1:0]   alloc_q2_tag,
    input  logic               cdb_valid,
    input  logic [TAG_W-1:0]   cdb_tag,
    output logic               issue_valid,
    output logic [IDX_W-1:0]   issue_idx,
    input  logic               issue_ready,
    output logic [RS_SIZE-1:0] wake1_idx_v,
    output logic [RS_SIZE-1:0] wake2_idx_v,
    output logic [IDX_W:0]     count,
    output logic               full,
    output logic               empty
);

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [RS_SIZE-1:0] pend1_q, pend1_d;
    logic [RS_SIZE-1:0] pend2_q, pend2_d;
    logic [TAG_W-1:0]   tag1_q [RS_SIZE];
    logic [TAG_W-1:0]   tag1_d [RS_SIZE];
    logic [TAG_W-1:0]   tag2_q [RS_SIZE];
    logic [TAG_W-1:0]   tag2_d [RS_SIZE];
    // older_q[j][k] = 1 means entry j was allocated before entry k
    logic [RS_SIZE-1:0] older_q [RS_SIZE];
    logic [RS_SIZE-1:0] older_d [RS_SIZE];
    logic [RS_SIZE-1:0] older_col [RS_SIZE];
    logic [IDX_W:0]     count_q, count_d;

    logic               active;
    logic               alloc_found;
    logic               issue_found;
    logic               alloc_fire;
    logic               issue_fire;
    logic               byp1;
    logic               byp2;
    logic [RS_SIZE-1:0] free_vec;
    logic [RS_SIZE-1:0] ready;
    logic [RS_SIZE-1:0] issue_sel;
    logic [RS_SIZE-1:0] alloc_oh;
    logic [RS_SIZE-1:0] issue_oh;
    logic [RS_SIZE-1:0] busy_kept;

    assign active   = rdy_in & ~rob_clear_up;
    assign free_vec = ~busy_q;
    assign ready    = busy_q & ~pend1_q & ~pend2_q;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            for (int k = 0; k < RS_SIZE; k++) begin
                older_col[i][k] = older_q[k][i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_sel
            assign issue_sel[gi] = ready[gi] & ~|(ready & older_col[gi]);
        end
    endgenerate

    rs_issue_scheduler_lowest_free u_alloc_enc (
        .req_i   (free_vec),
        .idx_o   (alloc_idx),
        .found_o (alloc_found)
    );

    rs_issue_scheduler_lowest_free u_issue_enc (
        .req_i   (issue_sel),
        .idx_o   (issue_idx),
        .found_o (issue_found)
    );

    assign count       = count_q;
    assign full        = (count_q == RS_FULL_COUNT);
    assign empty       = (count_q == '0);
    assign alloc_rdy   = rdy_in & ~full & alloc_found;
    assign alloc_fire  = alloc_valid & alloc_rdy & ~rob_clear_up;
    assign issue_valid = active & issue_found;
    assign issue_fire  = issue_valid & issue_ready;
    assign alloc_oh    = alloc_fire ? idx_onehot(alloc_idx) : '0;
    assign issue_oh    = issue_fire ? idx_onehot(issue_idx) : '0;
    assign busy_kept   = busy_q & ~issue_oh;
    assign byp1        = cdb_valid & alloc_q1_pend & (alloc_q1_tag == cdb_tag);
    assign byp2        = cdb_valid & alloc_q2_pend & (alloc_q2_tag == cdb_tag);

    always_comb begin
        wake1_idx_v = '0;
        wake2_idx_v = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            wake1_idx_v[i] = active & cdb_valid & busy_q[i] & pend1_q[i] & (tag1_q[i] == cdb_tag);
            wake2_idx_v[i] = active & cdb_valid & busy_q[i] & pend2_q[i] & (tag2_q[i] == cdb_tag);
        end
        // A CDB hit on the entry being allocated is captured by the payload array too
        wake1_idx_v = wake1_idx_v | (alloc_oh & {RS_SIZE{byp1}});
        wake2_idx_v = wake2_idx_v | (alloc_oh & {RS_SIZE{byp2}});
    end

    always_comb begin
        busy_d  = busy_q;
        pend1_d = pend1_q;
        pend2_d = pend2_q;
        count_d = count_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            tag1_d[i]  = tag1_q[i];
            tag2_d[i]  = tag2_q[i];
            older_d[i] = older_q[i];
        end
        if (rdy_in) begin
            if (rob_clear_up) begin
                busy_d  = '0;
                pend1_d = '0;
                pend2_d = '0;
                count_d = '0;
                for (int i = 0; i < RS_SIZE; i++) begin
                    older_d[i] = '0;
                end
            end else begin
                busy_d  = busy_kept | alloc_oh;
                pend1_d = (pend1_q & ~wake1_idx_v & ~alloc_oh)
                        | (alloc_oh & {RS_SIZE{alloc_q1_pend & ~byp1}});
                pend2_d = (pend2_q & ~wake2_idx_v & ~alloc_oh)
                        | (alloc_oh & {RS_SIZE{alloc_q2_pend & ~byp2}});
                for (int i = 0; i < RS_SIZE; i++) begin
                    older_d[i] = older_q[i] & ~issue_oh;
                end
                if (alloc_fire) begin
                    tag1_d[alloc_idx]  = alloc_q1_tag;
                    tag2_d[alloc_idx]  = alloc_q2_tag;
                    older_d[alloc_idx] = '0;
                    // Every surviving entry is older than the newcomer
                    for (int j = 0; j < RS_SIZE; j++) begin
                        older_d[j][alloc_idx] = busy_kept[j];
                    end
                end
                count_d = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(issue_fire);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q  <= '0;
            pend1_q <= '0;
            pend2_q <= '0;
            count_q <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                tag1_q[i]  <= '0;
                tag2_q[i]  <= '0;
                older_q[i] <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            pend1_q <= pend1_d;
            pend2_q <= pend2_d;
            count_q <= count_d;
            for (int i = 0; i < RS_SIZE; i++) begin
                tag1_q[i]  <= tag1_d[i];
                tag2_q[i]  <= tag2_d[i];
                older_q[i] <= older_d[i];
            end
        end
    end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed self-checking bench for rs_issue_scheduler.
module tb_rs_issue_scheduler;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear_up;
    logic        alloc_valid;
    logic        alloc_rdy;
    logic [3:0]  alloc_idx;
    logic        alloc_q1_pend;
    logic [3:0]  alloc_q1_tag;
    logic        alloc_q2_pend;
    logic [3:0]  alloc_q2_tag;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic        issue_valid;
    logic [3:0]  issue_idx;
    logic        issue_ready;
    logic [15:0] wake1_idx_v;
    logic [15:0] wake2_idx_v;
    logic [4:0]  count;
    logic        full;
    logic        empty;

    int tests_run;
    int tests_failed;

    rs_issue_scheduler dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .rob_clear_up  (rob_clear_up),
        .alloc_valid   (alloc_valid),
        .alloc_rdy     (alloc_rdy),
        .alloc_idx     (alloc_idx),
        .alloc_q1_pend (alloc_q1_pend),
        .alloc_q1_tag  (alloc_q1_tag),
        .alloc_q2_pend (alloc_q2_pend),
        .alloc_q2_tag  (alloc_q2_tag),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .issue_valid   (issue_valid),
        .issue_idx     (issue_idx),
        .issue_ready   (issue_ready),
        .wake1_idx_v   (wake1_idx_v),
        .wake2_idx_v   (wake2_idx_v),
        .count         (count),
        .full          (full),
        .empty         (empty)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] %s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst_in        = 1'b1;
        rdy_in        = 1'b1;
        rob_clear_up  = 1'b0;
        alloc_valid   = 1'b0;
        alloc_q1_pend = 1'b0;
        alloc_q1_tag  = 4'd0;
        alloc_q2_pend = 1'b0;
        alloc_q2_tag  = 4'd0;
        cdb_valid     = 1'b0;
        cdb_tag       = 4'd0;
        issue_ready   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_alloc_rdy", alloc_rdy, 1);
        chk("rst_alloc_idx", alloc_idx, 0);
        chk("rst_wake1", wake1_idx_v, 0);
        chk("rst_wake2", wake2_idx_v, 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        tick();

        // Fill all 16 entries in order
        for (int i = 0; i < 16; i++) begin
            alloc_valid = 1'b1;
            #1;
            chk("fill_alloc_idx", alloc_idx, i);
            tick();
        end
        alloc_valid = 1'b0;
        #1;
        chk("fill_count", count, 16);
        chk("fill_full", full, 1);
        chk("fill_alloc_rdy", alloc_rdy, 0);
        chk("fill_issue_idx", issue_idx, 0);

        // Full RS: concurrent issue and alloc; alloc is refused
        issue_ready = 1'b1;
        alloc_valid = 1'b1;
        #1;
        chk("full_alloc_rdy", alloc_rdy, 0);
        chk("full_issue_valid", issue_valid, 1);
        tick();
        issue_ready = 1'b0;
        alloc_valid = 1'b0;
        #1;
        chk("full_count_after", count, 15);
        chk("full_alloc_idx_freed", alloc_idx, 0);
        chk("full_not_full", full, 0);
        chk("full_next_oldest", issue_idx, 1);
        rob_clear_up = 1'b1;
        tick();
        rob_clear_up = 1'b0;
        #1;
        chk("flush1_empty", empty, 1);

        // A waits on tag 3, B ready; B issues first, then A after wakeup
        alloc_valid   = 1'b1;
        alloc_q1_pend = 1'b1;
        alloc_q1_tag  = 4'd3;
        #1;
        chk("wk_alloc_a", alloc_idx, 0);
        tick();
        alloc_q1_pend = 1'b0;
        alloc_q1_tag  = 4'd0;
        #1;
        chk("wk_alloc_b", alloc_idx, 1);
        tick();
        alloc_valid = 1'b0;
        #1;
        chk("wk_issue_valid_b", issue_valid, 1);
        chk("wk_issue_idx_b", issue_idx, 1);
        cdb_valid   = 1'b1;
        cdb_tag     = 4'd3;
        issue_ready = 1'b1;
        #1;
        chk("wk_wake1_a", wake1_idx_v, 16'h0001);
        chk("wk_wake2_none", wake2_idx_v, 0);
        chk("wk_issue_still_b", issue_idx, 1);
        tick();
        cdb_valid = 1'b0;
        #1;
        chk("wk_wake1_cleared", wake1_idx_v, 0);
        chk("wk_issue_valid_a", issue_valid, 1);
        chk("wk_issue_idx_a", issue_idx, 0);
        chk("wk_count", count, 1);
        tick();
        issue_ready = 1'b0;
        #1;
        chk("wk_empty", empty, 1);
        chk("wk_no_issue", issue_valid, 0);

        // Same-cycle bypass on operand 1
        alloc_valid   = 1'b1;
        alloc_q1_pend = 1'b1;
        alloc_q1_tag  = 4'd5;
        cdb_valid     = 1'b1;
        cdb_tag       = 4'd5;
        #1;
        chk("byp1_wake1", wake1_idx_v, 16'h0001);
        chk("byp1_issue_valid_now", issue_valid, 0);
        tick();
        alloc_valid   = 1'b0;
        alloc_q1_pend = 1'b0;
        cdb_valid     = 1'b0;
        #1;
        chk("byp1_issue_valid_next", issue_valid, 1);
        chk("byp1_issue_idx", issue_idx, 0);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;

        // Operand 2: no match, then later wakeup
        alloc_valid   = 1'b1;
        alloc_q2_pend = 1'b1;
        alloc_q2_tag  = 4'd7;
        cdb_valid     = 1'b1;
        cdb_tag       = 4'd9;
        #1;
        chk("q2_nomatch_wake2", wake2_idx_v, 0);
        tick();
        alloc_valid   = 1'b0;
        alloc_q2_pend = 1'b0;
        cdb_tag       = 4'd7;
        #1;
        chk("q2_wake2", wake2_idx_v, 16'h0001);
        chk("q2_not_ready_yet", issue_valid, 0);
        tick();
        cdb_valid = 1'b0;
        #1;
        chk("q2_ready", issue_valid, 1);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        #1;
        chk("q2_empty", empty, 1);

        // Age ordering: entry 2 older than re-allocated entry 0
        alloc_valid = 1'b1;
        repeat (3) tick();
        alloc_valid = 1'b0;
        issue_ready = 1'b1;
        #1;
        chk("age_first_issue", issue_idx, 0);
        tick();
        chk("age_second_issue", issue_idx, 1);
        tick();
        issue_ready = 1'b0;
        alloc_valid = 1'b1;
        #1;
        chk("age_realloc_idx", alloc_idx, 0);
        tick();
        alloc_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("age_hold_valid", issue_valid, 1);
            chk("age_hold_idx", issue_idx, 2);
            tick();
        end
        issue_ready = 1'b1;
        #1;
        chk("age_fire_idx2", issue_idx, 2);
        tick();
        chk("age_fire_idx0", issue_idx, 0);
        tick();
        issue_ready = 1'b0;
        #1;
        chk("age_empty", empty, 1);

        // Pause mid-fill, then flush with a concurrent alloc request
        alloc_valid = 1'b1;
        repeat (3) tick();
        rdy_in = 1'b0;
        #1;
        chk("pause_alloc_rdy", alloc_rdy, 0);
        chk("pause_issue_valid", issue_valid, 0);
        tick();
        tick();
        chk("pause_count_hold", count, 3);
        rdy_in = 1'b1;
        repeat (2) tick();
        rob_clear_up = 1'b1;
        #1;
        chk("flush_count_before", count, 5);
        chk("flush_alloc_rdy", alloc_rdy, 1);
        chk("flush_issue_valid", issue_valid, 0);
        tick();
        rob_clear_up = 1'b0;
        alloc_valid  = 1'b0;
        #1;
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_no_issue", issue_valid, 0);
        chk("flush_alloc_idx", alloc_idx, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
